// File: rtl/if_stage.sv
// Instruction fetch stage: holds the PC, issues one outstanding request at a
// time to instruction memory, and feeds the IF/ID register read by the decoder.
//
// Handshake: imem_req/imem_gnt is valid/ready. A request transfers in a cycle
// where both are high. The response arrives as a single imem_rvalid pulse no
// earlier than the cycle after the grant. The IF/ID side is valid/stall: decode
// takes the entry in any cycle with id_valid && !stall.
module if_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic [1:0]      dbg_state    // 0 REQ, 1 WAIT, 2 HOLD, 3 DROP
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // presenting a request
        S_WAIT = 2'd1,   // granted, waiting for the response
        S_HOLD = 2'd2,   // response parked in the skid buffer behind a stall
        S_DROP = 2'd3    // waiting for a response that a redirect made stale
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next, pc_inc;
    logic [XLEN-1:0] skid_pc, skid_pc_next;
    logic [31:0]     skid_instr, skid_instr_next;
    logic            id_valid_next;
    logic [XLEN-1:0] id_pc_next;
    logic [31:0]     id_instr_next;

    assign imem_req  = (state == S_REQ) && !rst;
    assign imem_addr = pc;
    assign id_opcode = id_instr[6:0];
    assign dbg_state = state;
    assign pc_inc    = pc + XLEN'(4);

    // State, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            skid_pc    <= '0;
            skid_instr <= NOP;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_instr   <= NOP;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            skid_pc    <= skid_pc_next;
            skid_instr <= skid_instr_next;
            id_valid   <= id_valid_next;
            id_pc      <= id_pc_next;
            id_instr   <= id_instr_next;
        end
    end

    // Next-state logic; a redirect overrides stall and any arriving data.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        skid_pc_next    = skid_pc;
        skid_instr_next = skid_instr;
        id_valid_next   = id_valid;
        id_pc_next      = id_pc;
        id_instr_next   = id_instr;

        if (redirect) begin
            pc_next       = {redirect_pc[XLEN-1:2], 2'b00};
            id_valid_next = 1'b0;
            case (state)
                S_REQ:   if (imem_gnt) state_next = S_DROP;
                S_WAIT:  state_next = imem_rvalid ? S_REQ : S_DROP;
                S_HOLD:  state_next = S_REQ;
                S_DROP:  if (imem_rvalid) state_next = S_REQ;
                default: state_next = S_REQ;
            endcase
        end else begin
            // Decode takes the current entry; a load below may refill it.
            if (id_valid && !stall) id_valid_next = 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_gnt) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_next = pc_inc;
                        if (!id_valid || !stall) begin
                            id_valid_next = 1'b1;
                            id_pc_next    = pc;
                            id_instr_next = imem_rdata;
                            state_next    = S_REQ;
                        end else begin
                            skid_pc_next    = pc;
                            skid_instr_next = imem_rdata;
                            state_next      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        id_valid_next = 1'b1;
                        id_pc_next    = skid_pc;
                        id_instr_next = skid_instr;
                        state_next    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) state_next = S_REQ;
                end
                default: state_next = S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a 64-bit and a 32-bit instance share one stimulus stream
// (the 32-bit one sees the low half of redirect_pc). A reference model tracks
// the fetch stage as "request in flight / in flight but stale / parked word /
// IF/ID entry" and the memory as a single pending-response flag.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        req64, req32, idv64, idv32;
    logic [63:0] addr64, idpc64;
    logic [31:0] addr32, idpc32, instr64, instr32;
    logic [6:0]  opc64, opc32;
    logic [1:0]  st64, st32;

    if_stage #(.XLEN(64), .RESET_PC(64'd0)) u_dut64 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(req64), .imem_addr(addr64),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(idv64), .id_pc(idpc64), .id_instr(instr64), .id_opcode(opc64),
        .dbg_state(st64)
    );

    if_stage #(.XLEN(32), .RESET_PC(32'd0)) u_dut32 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc[31:0]), .imem_req(req32), .imem_addr(addr32),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(idv32), .id_pc(idpc32), .id_instr(instr32), .id_opcode(opc32),
        .dbg_state(st32)
    );

    // Clock.
    always #5 clk = ~clk;

    // Reference model state.
    logic [63:0] m_pc;
    bit          m_issued, m_stale, m_skid_v, m_id_v, m_fresh, mem_pending;
    logic [63:0] m_skid_pc, m_id_pc;
    logic [31:0] m_skid_instr, m_id_instr;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_req();
        return !m_issued && !m_skid_v;
    endfunction

    function automatic logic [1:0] model_state();
        if (m_skid_v) return 2'd2;
        if (m_issued) return m_stale ? 2'd3 : 2'd1;
        return 2'd0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit req, slot_free;
        req = model_req();
        if (rst) begin
            m_pc = 64'd0; m_issued = 0; m_stale = 0; m_skid_v = 0;
            m_id_v = 0; m_id_pc = 64'd0; m_id_instr = NOP; m_fresh = 1;
            mem_pending = 0;
            return;
        end
        if (imem_rvalid) mem_pending = 0;
        if (imem_gnt && req) mem_pending = 1;
        if (redirect) begin
            m_pc = {redirect_pc[63:2], 2'b00};
            m_id_v = 0;
            m_skid_v = 0;
            if (req && imem_gnt) begin
                m_issued = 1; m_stale = 1;
            end else if (m_issued) begin
                if (imem_rvalid) begin m_issued = 0; m_stale = 0; end
                else m_stale = 1;
            end
        end else begin
            slot_free = !m_id_v || !stall;
            if (!stall) m_id_v = 0;
            if (req) begin
                if (imem_gnt) m_issued = 1;
            end else if (m_skid_v) begin
                if (!stall) begin
                    m_id_v = 1; m_id_pc = m_skid_pc; m_id_instr = m_skid_instr;
                    m_skid_v = 0; m_fresh = 0;
                end
            end else if (imem_rvalid) begin
                m_issued = 0;
                if (m_stale) begin
                    m_stale = 0;
                end else begin
                    if (slot_free) begin
                        m_id_v = 1; m_id_pc = m_pc; m_id_instr = imem_rdata; m_fresh = 0;
                    end else begin
                        m_skid_v = 1; m_skid_pc = m_pc; m_skid_instr = imem_rdata;
                    end
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_req;
        exp_req = model_req() && !rst;
        check("req64", 64'(req64), 64'(exp_req));
        check("req32", 64'(req32), 64'(exp_req));
        check("addr64", addr64, m_pc);
        check("addr32", 64'(addr32), 64'(m_pc[31:0]));
        check("state64", 64'(st64), 64'(model_state()));
        check("state32", 64'(st32), 64'(model_state()));
        check("idv64", 64'(idv64), 64'(m_id_v));
        check("idv32", 64'(idv32), 64'(m_id_v));
        if (m_id_v || m_fresh) begin
            check("idpc64", idpc64, m_id_pc);
            check("idpc32", 64'(idpc32), 64'(m_id_pc[31:0]));
            check("instr64", 64'(instr64), 64'(m_id_instr));
            check("instr32", 64'(instr32), 64'(m_id_instr));
            check("opc64", 64'(opc64), 64'(m_id_instr[6:0]));
            check("opc32", 64'(opc32), 64'(m_id_instr[6:0]));
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, check at negedge.
    task automatic drive(input bit r, input bit st, input bit rd, input logic [63:0] rpc,
                         input bit g, input bit rv, input logic [31:0] data);
        rst = r; stall = st; redirect = rd; redirect_pc = rpc;
        imem_gnt = g; imem_rvalid = rv; imem_rdata = data;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        @(negedge clk);
        // Reset and test 1: first fetch from 0.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("t1_rst_req", 64'(req64), 64'd0);
        check("t1_rst_instr", 64'(instr64), 64'(NOP));
        check("t1_addr0", addr64, 64'd0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h00A0_0093);
        check("t1_idv", 64'(idv64), 64'd1);
        check("t1_idpc", idpc64, 64'd0);
        check("t1_opc", 64'(opc64), 64'h13);
        check("t1_addr4", addr64, 64'd4);

        // Test 2: stall while the second word arrives, then drain in order.
        drive(0, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 32'h1111_1111);
        check("t2_hold", 64'(st64), 64'd2);
        check("t2_req0", 64'(req64), 64'd0);
        check("t2_word0", 64'(instr64), 64'h00A0_0093);
        drive(0, 1, 0, 0, 0, 0, 0);
        check("t2_word0_held", 64'(instr64), 64'h00A0_0093);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t2_word1", 64'(instr64), 64'h1111_1111);
        check("t2_word1_pc", idpc64, 64'd4);
        drive(0, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 32'h2222_2222);
        check("t2_word1_still", 64'(instr64), 64'h1111_1111);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t2_word2", 64'(instr64), 64'h2222_2222);
        check("t2_word2_pc", idpc64, 64'd8);

        // Test 3: redirect in WAIT before the response arrives.
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 64'h100, 0, 0, 0);
        check("t3_idv0", 64'(idv64), 64'd0);
        check("t3_drop", 64'(st64), 64'd3);
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("t3_stale_idv", 64'(idv64), 64'd0);
        check("t3_addr", addr64, 64'h100);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h3333_3333);
        check("t3_idpc", idpc64, 64'h100);

        // Test 4: redirect to a misaligned target together with rvalid.
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 64'h203, 0, 1, 32'hBAD0_BAD0);
        check("t4_addr", addr64, 64'h200);
        check("t4_idv0", 64'(idv64), 64'd0);

        // Test 5: PC wrap at the top of the address space, 32 and 64 bit.
        drive(0, 0, 1, 64'hFFFF_FFFC, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h4444_4444);
        check("t5_idpc32", 64'(idpc32), 64'hFFFF_FFFC);
        check("t5_addr32", 64'(addr32), 64'd0);
        check("t5_addr64", addr64, 64'h1_0000_0000);
        drive(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h5555_5555);
        check("t5_idpc64", idpc64, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_wrap64", addr64, 64'd0);

        // Test 6: reset while parked in HOLD under stall.
        drive(0, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 32'h6666_6666);
        check("t6_hold", 64'(st64), 64'd2);
        drive(1, 1, 0, 0, 0, 0, 0);
        check("t6_idv0", 64'(idv64), 64'd0);
        check("t6_nop", 64'(instr64), 64'(NOP));
        check("t6_pc", addr64, 64'd0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h7777_7777);
        check("t6_resume_pc", idpc64, 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, st, rd, g, rv;
            logic [63:0] rpc;
            r   = ($urandom_range(0, 63) == 0);
            st  = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) rpc[63:32] = 32'hFFFF_FFFF;
            g   = model_req() && !r && ($urandom_range(0, 3) != 0);
            rv  = mem_pending && !r && ($urandom_range(0, 2) != 0);
            drive(r, st, rd, rpc, g, rv, $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
